// File: rtl/mem_responder_if.sv
// -----------------------------------------------------------------------------
// mem_responder_if
// Core-side memory request/response bundle between a core (master) and the
// memory responder (slave).
//
// Signals:
//   mem_read       master->slave  read request this cycle
//   mem_wren       master->slave  write request this cycle
//   mem_addr       master->slave  byte address
//   mem_size       master->slave  0 = byte, 1 = half, 2 = word, 3 = illegal
//   memwrite_data  master->slave  right-aligned store data
//   memread_data   slave->master  right-aligned, zero-extended load data
//   mem_fault      slave->master  one-cycle pulse after a faulting request
// -----------------------------------------------------------------------------
interface mem_responder_if #(
    parameter int WDATA = 32,
    parameter int WPTR  = 32
);
    logic             mem_read;
    logic             mem_wren;
    logic [WPTR-1:0]  mem_addr;
    logic [1:0]       mem_size;
    logic [WDATA-1:0] memwrite_data;
    logic [WDATA-1:0] memread_data;
    logic             mem_fault;

    modport master (
        output mem_read, mem_wren, mem_addr, mem_size, memwrite_data,
        input  memread_data, mem_fault
    );

    modport slave (
        input  mem_read, mem_wren, mem_addr, mem_size, memwrite_data,
        output memread_data, mem_fault
    );
endinterface

// File: rtl/mem_responder.sv
// -----------------------------------------------------------------------------
// mem_responder
// Memory-side responder: word-organised RAM with byte-lane writes and a
// registered right-aligned read path, request checking (misaligned, illegal
// size, out of range, read+write conflict) and a tohost mailbox with a
// valid/ack handshake. A backdoor port preloads whole words.
//
// Ports:
//   clk             clock, rising edge
//   rst             synchronous reset, active low
//   bus             mem_responder_if.slave (core request/response)
//   tohost_valid    mailbox holds an unconsumed value
//   tohost_data     mailbox contents
//   tohost_ack      host consumes the mailbox
//   tohost_overrun  sticky: mailbox store while tohost_valid was high (no ack)
//   ld_en/ld_addr/ld_data  backdoor word preload (ignored in reset)
// -----------------------------------------------------------------------------
module mem_responder #(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000,
    parameter int          WDATA       = 32,
    parameter int          WPTR        = 32
) (
    input  logic             clk,
    input  logic             rst,
    mem_responder_if.slave   bus,
    output logic             tohost_valid,
    output logic [WDATA-1:0] tohost_data,
    input  logic             tohost_ack,
    output logic             tohost_overrun,
    input  logic             ld_en,
    input  logic [WPTR-1:0]  ld_addr,
    input  logic [WDATA-1:0] ld_data
);
    localparam int AW = $clog2(DEPTH_WORDS);

    // Byte-enable pattern for the addressed lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'd0:    lane_mask = 4'b0001 << off;
            2'd1:    lane_mask = off[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    // Replicate the right-aligned store data across the word; the lane mask
    // then picks the copy that lands in the addressed lanes.
    function automatic logic [WDATA-1:0] align_store(input logic [1:0] size,
                                                     input logic [WDATA-1:0] data);
        case (size)
            2'd0:    align_store = {4{data[7:0]}};
            2'd1:    align_store = {2{data[15:0]}};
            default: align_store = data;
        endcase
    endfunction

    // Shift the addressed byte/half down to bit 0 and zero-extend.
    function automatic logic [WDATA-1:0] extract_load(input logic [1:0] size,
                                                      input logic [1:0] off,
                                                      input logic [WDATA-1:0] word);
        logic [WDATA-1:0] shifted;
        shifted = word >> {off, 3'b000};
        case (size)
            2'd0:    extract_load = {24'b0, shifted[7:0]};
            2'd1:    extract_load = {16'b0, shifted[15:0]};
            default: extract_load = word;
        endcase
    endfunction

    logic [3:0][7:0]  ram [DEPTH_WORDS];

    logic             req;
    logic             in_ram;
    logic             in_tohost;
    logic             size_bad;
    logic             bad;
    logic             ram_write;
    logic             rd_ok;
    logic             tohost_store;
    logic [1:0]       off;
    logic [AW-1:0]    idx;
    logic [3:0]       wmask;
    logic [WDATA-1:0] wword;
    logic [WDATA-1:0] rword;
    logic             ld_hit;
    logic [AW-1:0]    ld_idx;

    // Request decode and validity, all in the request cycle.
    always_comb begin
        off       = bus.mem_addr[1:0];
        idx       = bus.mem_addr[AW+1:2];
        req       = bus.mem_read | bus.mem_wren;
        in_ram    = (bus.mem_addr >> (AW + 2)) == '0;
        in_tohost = bus.mem_addr[WPTR-1:2] == TOHOST_ADDR[WPTR-1:2];

        size_bad  = (bus.mem_size == 2'd3)
                  || (bus.mem_size == 2'd1 && off[0])
                  || (bus.mem_size == 2'd2 && off != 2'd0);

        // The mailbox only accepts full-word stores.
        bad       = (bus.mem_read && bus.mem_wren)
                  || size_bad
                  || !(in_ram || in_tohost)
                  || (bus.mem_wren && in_tohost && bus.mem_size != 2'd2);

        ram_write    = req && !bad && bus.mem_wren && in_ram;
        tohost_store = req && !bad && bus.mem_wren && in_tohost;
        rd_ok        = req && !bad && bus.mem_read;

        wmask = lane_mask(bus.mem_size, off);
        wword = align_store(bus.mem_size, bus.memwrite_data);
        rword = in_tohost ? {{(WDATA-1){1'b0}}, tohost_valid} : ram[idx];

        ld_hit = ld_en && ((ld_addr >> (AW + 2)) == '0);
        ld_idx = ld_addr[AW+1:2];
    end

    // Storage: backdoor word first, so a same-cycle core write to the same
    // word overrides it on the core's lanes. Nothing is written in reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            if (ld_hit) begin
                ram[ld_idx] <= ld_data;
            end
            if (ram_write) begin
                for (int b = 0; b < 4; b++) begin
                    if (wmask[b]) begin
                        ram[idx][b] <= wword[8*b +: 8];
                    end
                end
            end
        end
    end

    // Response: registered load data (held until the next valid read) and
    // the fault pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bus.memread_data <= '0;
            bus.mem_fault    <= 1'b0;
        end else begin
            bus.mem_fault <= req && bad;
            if (rd_ok) begin
                bus.memread_data <= extract_load(bus.mem_size, off, rword);
            end
        end
    end

    // Mailbox: a store always wins over a same-cycle ack; overrun only when
    // an unconsumed value is overwritten without being acknowledged.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tohost_valid   <= 1'b0;
            tohost_data    <= '0;
            tohost_overrun <= 1'b0;
        end else if (tohost_store) begin
            tohost_data  <= bus.memwrite_data;
            tohost_valid <= 1'b1;
            if (tohost_valid && !tohost_ack) begin
                tohost_overrun <= 1'b1;
            end
        end else if (tohost_ack) begin
            tohost_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// -----------------------------------------------------------------------------
// tb_mem_responder
// Directed scenarios plus randomized traffic against a byte-addressed
// behavioural model of the responder; a compare process checks every output
// against the model each cycle, and literal expectations pin the model.
// -----------------------------------------------------------------------------
module tb_mem_responder;
    localparam int          D   = 64;
    localparam logic [31:0] TOH = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    logic        tohost_ack = 1'b0;
    logic        tohost_overrun;
    logic        ld_en = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [31:0] ld_data = '0;

    mem_responder_if bus ();

    mem_responder #(.DEPTH_WORDS(D), .TOHOST_ADDR(TOH)) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .tohost_valid   (tohost_valid),
        .tohost_data    (tohost_data),
        .tohost_ack     (tohost_ack),
        .tohost_overrun (tohost_overrun),
        .ld_en          (ld_en),
        .ld_addr        (ld_addr),
        .ld_data        (ld_data)
    );

    always #5 clk = ~clk;

    // Behavioural model state: memory as a flat byte array.
    logic [7:0]  mem_b [4*D];
    logic [31:0] m_rdata = '0;
    logic        m_fault = 1'b0;
    logic        m_tv    = 1'b0;
    logic [31:0] m_td    = '0;
    logic        m_ovr   = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance the model by one clock edge using the inputs presented in it.
    task automatic model_step();
        logic [31:0] a;
        logic        r, w, req, bad, in_ram, at_toh;
        logic [1:0]  s;
        logic [31:0] wd, val;
        int          nb;
        a  = bus.mem_addr;
        r  = bus.mem_read;
        w  = bus.mem_wren;
        s  = bus.mem_size;
        wd = bus.memwrite_data;
        if (!rst) begin
            m_rdata = '0; m_fault = 1'b0; m_tv = 1'b0; m_td = '0; m_ovr = 1'b0;
            return;
        end
        req    = r || w;
        in_ram = a < 32'(4*D);
        at_toh = (a >= TOH) && ((a - TOH) < 32'd4);
        bad    = (r && w) || (s == 2'd3) || (s == 2'd1 && a % 2 != 0)
              || (s == 2'd2 && a % 4 != 0) || !(in_ram || at_toh)
              || (w && at_toh && s != 2'd2);
        m_fault = req && bad;
        nb = 1 << s;
        // Loads observe memory as it was before this edge.
        if (req && !bad && r) begin
            if (at_toh) val = {31'b0, m_tv} >> (8 * (a - TOH));
            m_rdata = '0;
            for (int i = 0; i < nb; i++)
                m_rdata[8*i +: 8] = at_toh ? val[8*i +: 8] : mem_b[a + 32'(i)];
        end
        if (ld_en && ld_addr < 32'(4*D))
            for (int i = 0; i < 4; i++) mem_b[(ld_addr & ~32'd3) + 32'(i)] = ld_data[8*i +: 8];
        if (req && !bad && w && !at_toh)
            for (int i = 0; i < nb; i++) mem_b[a + 32'(i)] = wd[8*i +: 8];
        if (req && !bad && w && at_toh) begin
            if (m_tv && !tohost_ack) m_ovr = 1'b1;
            m_td = wd;
            m_tv = 1'b1;
        end else if (tohost_ack) begin
            m_tv = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        bus.mem_read = 1'b0;
        bus.mem_wren = 1'b0;
        tohost_ack   = 1'b0;
        ld_en        = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] s);
        bus.mem_read = 1'b1; bus.mem_addr = a; bus.mem_size = s;
        tick();
    endtask

    task automatic wr(input logic [31:0] a, input logic [1:0] s, input logic [31:0] d);
        bus.mem_wren = 1'b1; bus.mem_addr = a; bus.mem_size = s; bus.memwrite_data = d;
        tick();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("memread_data", bus.memread_data, m_rdata);
            chk("mem_fault", {31'b0, bus.mem_fault}, {31'b0, m_fault});
            chk("tohost_valid", {31'b0, tohost_valid}, {31'b0, m_tv});
            chk("tohost_data", tohost_data, m_td);
            chk("tohost_overrun", {31'b0, tohost_overrun}, {31'b0, m_ovr});
        end
    end

    initial begin
        bus.mem_read = 1'b0; bus.mem_wren = 1'b0; bus.mem_addr = '0;
        bus.mem_size = 2'd0; bus.memwrite_data = '0;
        rst = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        chk("reset memread_data", bus.memread_data, 32'h0);
        chk("reset mem_fault", {31'b0, bus.mem_fault}, 32'h0);
        chk("reset tohost_valid", {31'b0, tohost_valid}, 32'h0);
        chk("reset tohost_data", tohost_data, 32'h0);
        chk("reset tohost_overrun", {31'b0, tohost_overrun}, 32'h0);
        rst = 1'b1;

        for (int k = 0; k < D; k++) begin
            ld_en = 1'b1; ld_addr = 32'(4*k); ld_data = $urandom;
            tick();
        end
        ld_en = 1'b1; ld_addr = 32'h10; ld_data = 32'h1122_3344;
        tick();

        rd(32'h10, 2'd2); chk("word read 0x10", bus.memread_data, 32'h1122_3344);
        rd(32'h10, 2'd0); chk("byte read 0x10", bus.memread_data, 32'h44);
        rd(32'h11, 2'd0); chk("byte read 0x11", bus.memread_data, 32'h33);
        rd(32'h12, 2'd0); chk("byte read 0x12", bus.memread_data, 32'h22);
        rd(32'h13, 2'd0); chk("byte read 0x13", bus.memread_data, 32'h11);
        rd(32'h12, 2'd1); chk("half read 0x12", bus.memread_data, 32'h1122);

        wr(32'h11, 2'd0, 32'hAB);
        rd(32'h10, 2'd2); chk("after byte store", bus.memread_data, 32'h1122_AB44);
        wr(32'h12, 2'd1, 32'hBEEF);
        rd(32'h10, 2'd2); chk("after half store", bus.memread_data, 32'hBEEF_AB44);

        rd(32'h02, 2'd2);
        chk("fault misaligned word read", {31'b0, bus.mem_fault}, 32'h1);
        chk("fault keeps memread_data", bus.memread_data, 32'hBEEF_AB44);
        tick();
        chk("fault is one cycle", {31'b0, bus.mem_fault}, 32'h0);
        wr(32'h05, 2'd1, 32'hFFFF);
        chk("fault misaligned half write", {31'b0, bus.mem_fault}, 32'h1);
        rd(32'h10, 2'd3);
        chk("fault size 3", {31'b0, bus.mem_fault}, 32'h1);
        rd(32'(4*D), 2'd2);
        chk("fault out of range", {31'b0, bus.mem_fault}, 32'h1);
        bus.mem_read = 1'b1; bus.mem_wren = 1'b1; bus.mem_addr = 32'h10;
        bus.mem_size = 2'd2; bus.memwrite_data = 32'h0;
        tick();
        chk("fault read+write", {31'b0, bus.mem_fault}, 32'h1);
        rd(32'h10, 2'd2);
        chk("RAM unchanged after faults", bus.memread_data, 32'hBEEF_AB44);
        rd(32'h04, 2'd2);

        wr(TOH, 2'd2, 32'h1);
        chk("mailbox valid", {31'b0, tohost_valid}, 32'h1);
        chk("mailbox data 1", tohost_data, 32'h1);
        wr(TOH, 2'd2, 32'h2);
        chk("mailbox data 2", tohost_data, 32'h2);
        chk("mailbox overrun", {31'b0, tohost_overrun}, 32'h1);
        tohost_ack = 1'b1;
        tick();
        chk("mailbox acked", {31'b0, tohost_valid}, 32'h0);
        rd(TOH, 2'd2);
        chk("mailbox read after ack", bus.memread_data, 32'h0);
        chk("overrun sticky", {31'b0, tohost_overrun}, 32'h1);
        wr(TOH, 2'd0, 32'h33);
        chk("fault byte store mailbox", {31'b0, bus.mem_fault}, 32'h1);

        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("overrun cleared by reset", {31'b0, tohost_overrun}, 32'h0);
        wr(TOH, 2'd2, 32'h7);
        bus.mem_wren = 1'b1; bus.mem_addr = TOH; bus.mem_size = 2'd2;
        bus.memwrite_data = 32'h5; tohost_ack = 1'b1;
        tick();
        chk("store+ack valid", {31'b0, tohost_valid}, 32'h1);
        chk("store+ack data", tohost_data, 32'h5);
        chk("store+ack no overrun", {31'b0, tohost_overrun}, 32'h0);
        rd(TOH, 2'd2);
        chk("mailbox read valid", bus.memread_data, 32'h1);

        rst = 1'b0;
        wr(TOH, 2'd2, 32'h9);
        chk("reset drops store valid", {31'b0, tohost_valid}, 32'h0);
        chk("reset drops store data", tohost_data, 32'h0);
        rst = 1'b1;
        rd(32'h10, 2'd2);
        chk("RAM survives reset", bus.memread_data, 32'hBEEF_AB44);

        ld_en = 1'b1; ld_addr = 32'h20; ld_data = 32'hCAFE_F00D;
        bus.mem_wren = 1'b1; bus.mem_addr = 32'h21; bus.mem_size = 2'd0;
        bus.memwrite_data = 32'h77;
        tick();
        rd(32'h20, 2'd2);
        chk("core lanes beat preload", bus.memread_data, 32'hCAFE_770D);
        ld_en = 1'b1; ld_addr = 32'(4*D); ld_data = 32'h1234_5678;
        tick();
        chk("preload out of range no fault", {31'b0, bus.mem_fault}, 32'h0);

        for (int k = 0; k < 3000; k++) begin
            int kind, sel, sz;
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 9);
            sz   = $urandom_range(0, 7);
            rst  = ($urandom_range(0, 99) != 0);
            bus.mem_read = (kind <= 3) || (kind == 7);
            bus.mem_wren = (kind >= 4 && kind <= 7);
            if (sel <= 6)      bus.mem_addr = $urandom_range(0, 4*D-1);
            else if (sel == 7) bus.mem_addr = TOH + $urandom_range(0, 3);
            else if (sel == 8) bus.mem_addr = TOH;
            else               bus.mem_addr = 32'(4*D) + $urandom_range(0, 64);
            bus.mem_size      = (sz < 7) ? 2'(sz % 3) : 2'd3;
            bus.memwrite_data = $urandom;
            tohost_ack        = ($urandom_range(0, 3) == 0);
            ld_en             = ($urandom_range(0, 7) == 0);
            ld_addr           = $urandom_range(0, 4*D+15) & ~32'd3;
            ld_data           = $urandom;
            tick();
        end
        rst = 1'b1;
        tick();

        @(negedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's data/instruction memory interface.
- Serves `mem_read`/`mem_wren` requests against an internal word-organised RAM with byte-lane writes and a registered, right-aligned read path.
- Detects misaligned, out-of-range and conflicting requests.
- Implements a memory-mapped tohost mailbox with a valid/ack handshake so the simulation host can observe program exit and console traffic.

Parameters:
- DEPTH_WORDS, 4096, number of 32-bit RAM words; must be a power of two; RAM covers byte addresses 0 .. 4*DEPTH_WORDS-1.
- TOHOST_ADDR, 32'h8000_0000, word-aligned byte address of the tohost mailbox; outside RAM range.
- WDATA, 32, data width (fixed).
- WPTR, 32, address width (fixed).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- mem_read  in  1  read request this cycle.
- mem_wren  in  1  write request this cycle.
- mem_addr  in  WPTR  byte address.
- mem_size  in  2  access size: 0 = byte, 1 = half, 2 = word; 3 = illegal.
- memwrite_data  in  WDATA  store data, right-aligned (byte in [7:0], half in [15:0]).
- memread_data  out  WDATA  load data, right-aligned, zero-extended.
- mem_fault  out  1  one-cycle pulse, the cycle after a faulting request.
- tohost_valid  out  1  mailbox holds an unconsumed value.
- tohost_data  out  WDATA  mailbox contents.
- tohost_ack  in  1  host consumes the mailbox.
- tohost_overrun  out  1  sticky: a mailbox store arrived while tohost_valid was high.
- ld_en  in  1  backdoor preload write, word granularity; ignored while rst=0.
- ld_addr  in  WPTR  backdoor word-aligned byte address.
- ld_data  in  WDATA  backdoor word.

Behaviour:
- Reset (rst=0 at a clk edge): memread_data=0, mem_fault=0, tohost_valid=0, tohost_data=0, tohost_overrun=0.
  - RAM contents are not cleared.
  - Reset mid-request discards that request.
  - Sticky and mailbox state clear.
- Request validity, evaluated in the request cycle. A request faults if any of the following hold:
  - mem_read and mem_wren are both 1;
  - mem_size=3;
  - half access with addr[0]=1;
  - word access with addr[1:0]!=0;
  - address is neither in the RAM range nor the word at TOHOST_ADDR.
- On a fault:
  - mem_fault=1 in the next cycle only.
  - No RAM or mailbox update occurs.
  - memread_data is unchanged.
- Write, mem_wren=1 and valid:
  - RAM updated at the clk edge on the selected lanes only.
  - Lane select is addr[1:0] for byte, addr[1] for half, all lanes for word.
  - Data is shifted from the right-aligned memwrite_data into the selected lanes.
  - Other bytes of the word are preserved.
- Read, mem_read=1 and valid:
  - memread_data updated at the clk edge (1-cycle latency).
  - The selected byte/half is shifted down to bit 0 and zero-extended; a word is returned as is.
  - memread_data holds its value until the next valid read.
- Read-after-write: a read in cycle N+1 returns data written in cycle N, with no bypass needed since storage updates at the edge.
- Tohost mailbox:
  - Word store to TOHOST_ADDR: tohost_data<=memwrite_data and tohost_valid<=1 next cycle.
  - Byte/half store to TOHOST_ADDR is a fault.
  - Reads of TOHOST_ADDR return {31'b0, tohost_valid}.
  - tohost_valid clears the cycle after tohost_ack=1.
  - Store and ack in the same cycle while valid: new data wins, valid stays 1, no overrun.
  - Store while valid=1 without ack: data overwritten, valid stays 1, tohost_overrun<=1 (sticky until reset).
  - tohost_ack while valid=0 is ignored.
- Backdoor preload:
  - ld_en writes a full word at ld_addr[.. :2].
  - If ld_en and a core write target the same word in the same cycle, the core write takes precedence on its lanes.
  - ld_addr out of range is ignored; no fault is raised.
- Idle (no request): no state change except the mailbox ack.

Test Plan:
- Preload word 0x11223344 at 0x10 via ld_en; read word 0x10 -> 0x11223344 next cycle; byte reads 0x10..0x13 -> 0x44, 0x33, 0x22, 0x11; half read 0x12 -> 0x1122.
- Byte store 0xAB at 0x11, then word read 0x10 -> 0x1122AB44; half store 0xBEEF at 0x12, then read -> 0xBEEFAB44.
- Faults: word read at 0x02, half write at 0x05, mem_size=3, address 4*DEPTH_WORDS, and read+write together -> mem_fault pulses 1 cycle each; RAM word and memread_data unchanged.
- Store 0x1 to TOHOST_ADDR -> tohost_valid=1, tohost_data=1. A second store of 0x2 without ack -> tohost_data=2, tohost_overrun=1. Ack -> valid=0. A read of TOHOST_ADDR afterwards returns 0.
- Same-cycle store 0x5 and ack while valid -> valid stays 1, data=5, overrun remains 0.
- Assert rst=0 the cycle a store to TOHOST_ADDR is issued -> mailbox stays 0 and invalid; previously written RAM words remain readable after reset release.
